l1_l2_write_buffer: RTL and testbench

Posted-write FIFO between the L1 data cache write port and the L2 cache. It accepts word writes from L1 through a valid/ready handshake and drains them in order to L2, one outstanding transaction at a time. It also provides a combinational lookup, so an L1 read miss can take the youngest buffered data for a matching address instead of reading stale data from L2.

---
 rtl/l1_l2_write_buffer.sv | 121 ++++++++++++
 tb/tb_l1_l2_write_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_write_buffer.sv
// Posted-write FIFO from the L1 write port to L2: in-order drain with one outstanding
// L2 write, plus youngest-match forwarding lookup for L1 read misses.
module l1_l2_write_buffer #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned L2_BUS_WIDTH  = 32,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned PTR_WIDTH     = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       WRITE_TO_L2_VALID_DATA,
  input  logic                       WRITE_CONTROL_TO_L2_DATA,
  input  logic [ADDRESS_WIDTH-3:0]   WRITE_ADDR_TO_L2_DATA,
  input  logic [L2_BUS_WIDTH-1:0]    DATA_TO_L2_DATA,
  output logic                       WRITE_TO_L2_READY_DATA,
  output logic                       WRITE_COMPLETE_DATA,
  output logic                       BUFFER_EMPTY,
  input  logic [ADDRESS_WIDTH-3:0]   LOOKUP_ADDR,
  output logic                       LOOKUP_HIT,
  output logic [L2_BUS_WIDTH-1:0]    LOOKUP_DATA,
  output logic                       L2_WRITE_VALID,
  input  logic                       L2_WRITE_READY,
  output logic [ADDRESS_WIDTH-3:0]   L2_WRITE_ADDR,
  output logic [L2_BUS_WIDTH-1:0]    L2_WRITE_DATA,
  input  logic                       L2_WRITE_DONE
);

  localparam int unsigned WAW = ADDRESS_WIDTH - 2;
  localparam int unsigned CW  = PTR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_e;

  state_e               state_q, state_d;
  logic [WAW-1:0]       addr_q [DEPTH];
  logic [L2_BUS_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 complete_q, complete_d;
  logic                 push, pop;

  logic                    lk_hit;
  logic [L2_BUS_WIDTH-1:0] lk_data;
  logic [PTR_WIDTH-1:0]    lk_idx;

  assign WRITE_TO_L2_READY_DATA = (count_q < CW'(DEPTH));
  assign BUFFER_EMPTY           = (count_q == '0);
  assign push = WRITE_TO_L2_VALID_DATA & WRITE_CONTROL_TO_L2_DATA & WRITE_TO_L2_READY_DATA;
  assign pop  = (state_q == WAIT_DONE) & L2_WRITE_DONE;

  assign L2_WRITE_VALID      = (state_q == REQ);
  assign L2_WRITE_ADDR       = addr_q[head_q];
  assign L2_WRITE_DATA       = data_q[head_q];
  assign WRITE_COMPLETE_DATA = complete_q;
  assign LOOKUP_HIT          = lk_hit;
  assign LOOKUP_DATA         = lk_data;

  // Pointer and occupancy update
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    complete_d = pop;
    if (push) tail_d = tail_q + PTR_WIDTH'(1);
    if (pop)  head_d = head_q + PTR_WIDTH'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM; the head entry stays stored until L2 reports DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (count_q != '0) state_d = REQ;
      REQ:       if (L2_WRITE_READY) state_d = WAIT_DONE;
      WAIT_DONE: if (L2_WRITE_DONE) state_d = (count_d != '0) ? REQ : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Walk oldest to youngest so the last match wins
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PTR_WIDTH'(i);
      if ((CW'(i) < count_q) && (addr_q[lk_idx] == LOOKUP_ADDR)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      complete_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      complete_q <= complete_d;
      if (push) begin
        addr_q[tail_q] <= WRITE_ADDR_TO_L2_DATA;
        data_q[tail_q] <= DATA_TO_L2_DATA;
      end
    end
  end

endmodule

// File: tb/tb_l1_l2_write_buffer.sv
// Bench for l1_l2_write_buffer: vector table for push/ready behaviour, scoreboard of
// expected L2 writes checked at each L2 handshake, and directed multi-cycle sequences.
module tb_l1_l2_write_buffer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WRITE_TO_L2_VALID_DATA = 1'b0;
  logic        WRITE_CONTROL_TO_L2_DATA = 1'b0;
  logic [29:0] WRITE_ADDR_TO_L2_DATA = '0;
  logic [31:0] DATA_TO_L2_DATA = '0;
  logic        WRITE_TO_L2_READY_DATA;
  logic        WRITE_COMPLETE_DATA;
  logic        BUFFER_EMPTY;
  logic [29:0] LOOKUP_ADDR = '0;
  logic        LOOKUP_HIT;
  logic [31:0] LOOKUP_DATA;
  logic        L2_WRITE_VALID;
  logic        L2_WRITE_READY = 1'b0;
  logic [29:0] L2_WRITE_ADDR;
  logic [31:0] L2_WRITE_DATA;
  logic        L2_WRITE_DONE = 1'b0;

  l1_l2_write_buffer dut (
    .CLK(CLK), .RST(RST),
    .WRITE_TO_L2_VALID_DATA(WRITE_TO_L2_VALID_DATA),
    .WRITE_CONTROL_TO_L2_DATA(WRITE_CONTROL_TO_L2_DATA),
    .WRITE_ADDR_TO_L2_DATA(WRITE_ADDR_TO_L2_DATA),
    .DATA_TO_L2_DATA(DATA_TO_L2_DATA),
    .WRITE_TO_L2_READY_DATA(WRITE_TO_L2_READY_DATA),
    .WRITE_COMPLETE_DATA(WRITE_COMPLETE_DATA),
    .BUFFER_EMPTY(BUFFER_EMPTY),
    .LOOKUP_ADDR(LOOKUP_ADDR),
    .LOOKUP_HIT(LOOKUP_HIT),
    .LOOKUP_DATA(LOOKUP_DATA),
    .L2_WRITE_VALID(L2_WRITE_VALID),
    .L2_WRITE_READY(L2_WRITE_READY),
    .L2_WRITE_ADDR(L2_WRITE_ADDR),
    .L2_WRITE_DATA(L2_WRITE_DATA),
    .L2_WRITE_DONE(L2_WRITE_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } l2w_t;

  typedef struct {
    logic        v;
    logic        c;
    logic [29:0] a;
    logic [31:0] d;
    logic        exp_ready;
    logic        exp_empty;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   hs_cnt = 0;
  int   cmp_cnt = 0;
  bit   l2_auto = 1'b0;
  bit   inflight = 1'b0;
  bit   man_ready = 1'b0;
  bit   man_done = 1'b0;
  l2w_t exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [29:0] a, input logic [31:0] d);
    WRITE_TO_L2_VALID_DATA   = 1'b1;
    WRITE_CONTROL_TO_L2_DATA = 1'b1;
    WRITE_ADDR_TO_L2_DATA    = a;
    DATA_TO_L2_DATA          = d;
    exp_q.push_back('{a: a, d: d});
    tick();
    WRITE_TO_L2_VALID_DATA   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (n < budget && !(BUFFER_EMPTY && !L2_WRITE_VALID)) begin
      tick();
      n++;
    end
    check("drain_within_budget", 32'(BUFFER_EMPTY && !L2_WRITE_VALID), 32'd1);
    tick();
    tick();
  endtask

  // L2 model (auto: READY one half-cycle after VALID, DONE the next cycle) and scoreboard
  always @(negedge CLK) begin
    if (l2_auto) begin
      L2_WRITE_DONE  = inflight;
      L2_WRITE_READY = L2_WRITE_VALID;
      inflight       = L2_WRITE_VALID;
    end else begin
      L2_WRITE_READY = man_ready;
      L2_WRITE_DONE  = man_done;
    end
    if (WRITE_COMPLETE_DATA) cmp_cnt++;
    if (!RST && L2_WRITE_VALID && L2_WRITE_READY) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL l2_unexpected_write: actual addr=%0h data=%0h required=none",
                 L2_WRITE_ADDR, L2_WRITE_DATA);
      end else begin
        l2w_t e;
        e = exp_q.pop_front();
        check("l2_addr", 32'(L2_WRITE_ADDR), 32'(e.a));
        check("l2_data", L2_WRITE_DATA, e.d);
      end
    end
  end

  initial begin
    int cmp_saved;

    // control-low no-ops, then fill with L2 stalled (5th write refused)
    for (int i = 0; i < 3; i++)
      vecs[i] = '{1'b1, 1'b0, 30'(32'h40 + i), 32'h5555_0000 + i, 1'b1, 1'b1};
    for (int i = 3; i < 8; i++)
      vecs[i] = '{1'b1, 1'b1, 30'(32'h100 + i - 3), 32'hA000 + i - 3, (i < 7), 1'b0};

    RST = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(WRITE_TO_L2_READY_DATA), 32'd1);
    check("rst_empty", 32'(BUFFER_EMPTY), 32'd1);
    check("rst_l2_valid", 32'(L2_WRITE_VALID), 32'd0);
    check("rst_complete", 32'(WRITE_COMPLETE_DATA), 32'd0);
    check("rst_hit", 32'(LOOKUP_HIT), 32'd0);
    check("rst_lookup_data", LOOKUP_DATA, 32'd0);
    check("rst_l2_addr", 32'(L2_WRITE_ADDR), 32'd0);
    check("rst_l2_data", L2_WRITE_DATA, 32'd0);
    RST = 1'b0;
    l2_auto = 1'b1;

    for (int i = 0; i < 3; i++) begin
      WRITE_TO_L2_VALID_DATA   = vecs[i].v;
      WRITE_CONTROL_TO_L2_DATA = vecs[i].c;
      WRITE_ADDR_TO_L2_DATA    = vecs[i].a;
      DATA_TO_L2_DATA          = vecs[i].d;
      #1;
      check("vec_ready", 32'(WRITE_TO_L2_READY_DATA), 32'(vecs[i].exp_ready));
      tick();
      check("vec_empty", 32'(BUFFER_EMPTY), 32'(vecs[i].exp_empty));
      check("ctl_low_no_l2", 32'(L2_WRITE_VALID), 32'd0);
    end
    WRITE_TO_L2_VALID_DATA = 1'b0;
    tick();
    check("ctl_low_no_handshake", 32'(hs_cnt), 32'd0);

    // single write and L1->L2 latency
    push_word(30'h10, 32'hDEAD_BEEF);
    check("single_empty_after_push", 32'(BUFFER_EMPTY), 32'd0);
    check("single_valid_k", 32'(L2_WRITE_VALID), 32'd0);
    tick();
    check("single_valid_k1", 32'(L2_WRITE_VALID), 32'd1);
    check("single_head_addr", 32'(L2_WRITE_ADDR), 32'h10);
    wait_drain(20);
    check("single_complete_cnt", 32'(cmp_cnt), 32'd1);
    check("single_hs_cnt", 32'(hs_cnt), 32'd1);
    check("single_empty_end", 32'(BUFFER_EMPTY), 32'd1);

    // fill with L2 stalled
    l2_auto   = 1'b0;
    man_ready = 1'b0;
    man_done  = 1'b0;
    for (int i = 3; i < 8; i++) begin
      WRITE_TO_L2_VALID_DATA   = vecs[i].v;
      WRITE_CONTROL_TO_L2_DATA = vecs[i].c;
      WRITE_ADDR_TO_L2_DATA    = vecs[i].a;
      DATA_TO_L2_DATA          = vecs[i].d;
      #1;
      check("vec_ready", 32'(WRITE_TO_L2_READY_DATA), 32'(vecs[i].exp_ready));
      if (vecs[i].v && vecs[i].c && vecs[i].exp_ready)
        exp_q.push_back('{a: vecs[i].a, d: vecs[i].d});
      tick();
      check("vec_empty", 32'(BUFFER_EMPTY), 32'(vecs[i].exp_empty));
    end
    check("full_ready_low", 32'(WRITE_TO_L2_READY_DATA), 32'd0);
    check("full_valid_held", 32'(L2_WRITE_VALID), 32'd1);
    check("full_head_addr", 32'(L2_WRITE_ADDR), 32'h100);
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    man_done  = 1'b1;
    check("simul_push_refused", 32'(WRITE_TO_L2_READY_DATA), 32'd0);
    tick();
    man_done = 1'b0;
    check("simul_complete_pulse", 32'(WRITE_COMPLETE_DATA), 32'd1);
    check("simul_ready_after_pop", 32'(WRITE_TO_L2_READY_DATA), 32'd1);
    check("simul_back_to_req", 32'(L2_WRITE_VALID), 32'd1);
    check("simul_next_head", 32'(L2_WRITE_ADDR), 32'h101);
    exp_q.push_back('{a: 30'h104, d: 32'hA004});
    tick();
    WRITE_TO_L2_VALID_DATA = 1'b0;
    check("simul_complete_one_cycle", 32'(WRITE_COMPLETE_DATA), 32'd0);
    check("refill_ready_low", 32'(WRITE_TO_L2_READY_DATA), 32'd0);
    l2_auto = 1'b1;
    wait_drain(40);
    check("fill_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("fill_complete_cnt", 32'(cmp_cnt), 32'd6);
    check("fill_hs_cnt", 32'(hs_cnt), 32'd6);

    // forwarding, including while the head is in flight
    l2_auto   = 1'b0;
    man_ready = 1'b0;
    man_done  = 1'b0;
    tick();
    push_word(30'h20, 32'h11);
    push_word(30'h20, 32'h22);
    push_word(30'h30, 32'h33);
    LOOKUP_ADDR = 30'h20;
    #1;
    check("fwd_hit_20", 32'(LOOKUP_HIT), 32'd1);
    check("fwd_data_20", LOOKUP_DATA, 32'h22);
    LOOKUP_ADDR = 30'h40;
    #1;
    check("fwd_hit_40", 32'(LOOKUP_HIT), 32'd0);
    check("fwd_data_40", LOOKUP_DATA, 32'd0);
    LOOKUP_ADDR = 30'h30;
    #1;
    check("fwd_data_30", LOOKUP_DATA, 32'h33);
    LOOKUP_ADDR = 30'h20;
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    check("fwd_in_wait_valid", 32'(L2_WRITE_VALID), 32'd0);
    check("fwd_in_wait_hit", 32'(LOOKUP_HIT), 32'd1);
    check("fwd_in_wait_data", LOOKUP_DATA, 32'h22);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("fwd_after_pop_data", LOOKUP_DATA, 32'h22);
    tick();
    check("fwd_complete_cnt", 32'(cmp_cnt), 32'd7);

    // reset in WAIT_DONE with three entries, then a stale DONE
    push_word(30'h50, 32'h55);
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    check("rst_mid_in_wait", 32'(L2_WRITE_VALID), 32'd0);
    cmp_saved = cmp_cnt;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_q.delete();
    LOOKUP_ADDR = 30'h30;
    #1;
    check("rst_mid_valid", 32'(L2_WRITE_VALID), 32'd0);
    check("rst_mid_empty", 32'(BUFFER_EMPTY), 32'd1);
    check("rst_mid_ready", 32'(WRITE_TO_L2_READY_DATA), 32'd1);
    check("rst_mid_hit", 32'(LOOKUP_HIT), 32'd0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("late_done_no_pulse", 32'(WRITE_COMPLETE_DATA), 32'd0);
    tick();
    check("late_done_no_pulse2", 32'(WRITE_COMPLETE_DATA), 32'd0);
    check("late_done_no_valid", 32'(L2_WRITE_VALID), 32'd0);
    tick();
    check("late_done_cmp_cnt", 32'(cmp_cnt), 32'(cmp_saved));
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
